// File: rtl/demux_1_to_3_fifo.sv
// Routes one input word stream to three 2-entry channel FIFOs selected by `select`.
// Optional build macro DEMUX_ERR_COUNT_EN adds a saturating dropped-word counter port.
module demux_1_to_3_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       select,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             valid_out2,
    input  logic             ready_in0,
    input  logic             ready_in1,
    input  logic             ready_in2,
    output logic             erro,
    output logic             vazio
`ifdef DEMUX_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    logic [WIDTH-1:0] mem_q   [3][2];
    logic [WIDTH-1:0] mem_d   [3][2];
    logic [WIDTH-1:0] dout_q  [3];
    logic [WIDTH-1:0] dout_d  [3];
    logic [1:0]       count_q [3];
    logic [1:0]       count_d [3];
    logic             wptr_q  [3];
    logic             wptr_d  [3];
    logic             rptr_q  [3];
    logic             rptr_d  [3];
    logic             erro_q;
    logic             erro_d;
    logic [2:0]       rd_req_s;
    logic [2:0]       wr_s;
    logic [2:0]       rd_s;
    logic             accept_s;
    logic             drop_s;

    assign rd_req_s = {ready_in2, ready_in1, ready_in0};
    assign accept_s = valid_in & ready_out;
    assign drop_s   = accept_s & (select == 2'b11);

    // Acceptance: invalid selects are always taken (and dropped); a full FIFO blocks even if it is being read.
    always_comb begin
        ready_out = 1'b0;
        case (select)
            2'b00:   ready_out = (count_q[0] != 2'd2);
            2'b01:   ready_out = (count_q[1] != 2'd2);
            2'b10:   ready_out = (count_q[2] != 2'd2);
            2'b11:   ready_out = 1'b1;
            default: ready_out = 1'b0;
        endcase
    end

    // Per-channel FIFO next state; the output register holds the post-edge head, or the last head once empty.
    always_comb begin
        mem_d   = mem_q;
        dout_d  = dout_q;
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        wr_s    = 3'b000;
        rd_s    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            wr_s[i] = accept_s & (select == 2'(i));
            rd_s[i] = (count_q[i] != 2'd0) & rd_req_s[i];
            if (wr_s[i]) begin
                mem_d[i][wptr_q[i]] = data_in;
            end else begin
                mem_d[i][wptr_q[i]] = mem_q[i][wptr_q[i]];
            end
            wptr_d[i]  = wptr_q[i] ^ wr_s[i];
            rptr_d[i]  = rptr_q[i] ^ rd_s[i];
            count_d[i] = count_q[i] + {1'b0, wr_s[i]} - {1'b0, rd_s[i]};
            if (count_d[i] != 2'd0) begin
                dout_d[i] = mem_d[i][rptr_d[i]];
            end else begin
                dout_d[i] = dout_q[i];
            end
        end
    end

    // Sticky flag for words dropped because of the invalid select code.
    always_comb begin
        if (drop_s) begin
            erro_d = 1'b1;
        end else begin
            erro_d = erro_q;
        end
    end

    // State registers; reset empties every FIFO and clears storage immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i][0] <= {WIDTH{1'b0}};
                mem_q[i][1] <= {WIDTH{1'b0}};
                dout_q[i]   <= {WIDTH{1'b0}};
                count_q[i]  <= 2'd0;
                wptr_q[i]   <= 1'b0;
                rptr_q[i]   <= 1'b0;
            end
            erro_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            erro_q  <= erro_d;
        end
    end

`ifdef DEMUX_ERR_COUNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    // Dropped-word counter saturates rather than wrapping.
    always_comb begin
        if (drop_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Dropped-word counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign data_out0  = dout_q[0];
    assign data_out1  = dout_q[1];
    assign data_out2  = dout_q[2];
    assign valid_out0 = (count_q[0] != 2'd0);
    assign valid_out1 = (count_q[1] != 2'd0);
    assign valid_out2 = (count_q[2] != 2'd0);
    assign erro       = erro_q;
    assign vazio      = (count_q[0] == 2'd0) && (count_q[1] == 2'd0) && (count_q[2] == 2'd0);

endmodule

// File: tb/tb_demux_1_to_3_fifo.sv
// Self-checking bench for demux_1_to_3_fifo: directed cases then random traffic vs. a queue-based model.
// Build with DEMUX_ERR_COUNT_EN defined to also check err_count.
module tb_demux_1_to_3_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [1:0]  select;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] data_out0, data_out1, data_out2;
    logic        valid_out0, valid_out1, valid_out2;
    logic        ready_in0, ready_in1, ready_in2;
    logic        erro;
    logic        vazio;
`ifdef DEMUX_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    demux_1_to_3_fifo #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .select(select),
        .valid_in(valid_in), .ready_out(ready_out),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
        .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2),
        .ready_in0(ready_in0), .ready_in1(ready_in1), .ready_in2(ready_in2),
        .erro(erro), .vazio(vazio)
`ifdef DEMUX_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: one queue per channel, last shown head, error flag and saturating drop count.
    logic [15:0] mq [3][$];
    logic [15:0] last_head [3];
    logic        m_erro;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete();
            last_head[c] = 16'h0000;
        end
        m_erro = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs();
        chk("valid_out0", {31'd0, valid_out0}, {31'd0, mq[0].size() != 0});
        chk("valid_out1", {31'd0, valid_out1}, {31'd0, mq[1].size() != 0});
        chk("valid_out2", {31'd0, valid_out2}, {31'd0, mq[2].size() != 0});
        chk("data_out0", {16'd0, data_out0}, {16'd0, last_head[0]});
        chk("data_out1", {16'd0, data_out1}, {16'd0, last_head[1]});
        chk("data_out2", {16'd0, data_out2}, {16'd0, last_head[2]});
        chk("vazio", {31'd0, vazio},
            {31'd0, (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0)});
        chk("erro", {31'd0, erro}, {31'd0, m_erro});
`ifdef DEMUX_ERR_COUNT_EN
        chk("err_count", {24'd0, err_count}, m_cnt);
`endif
    endtask

    // One clock of traffic: drive, check ready_out, advance model, then check outputs after the edge.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [15:0] d, input logic [2:0] r);
        logic exp_rdy;
        valid_in  = v;
        select    = sel;
        data_in   = d;
        ready_in0 = r[0];
        ready_in1 = r[1];
        ready_in2 = r[2];
        #1;
        if (sel == 2'b11) exp_rdy = 1'b1;
        else              exp_rdy = (mq[sel].size() < 2);
        chk("ready_out", {31'd0, ready_out}, {31'd0, exp_rdy});
        for (int c = 0; c < 3; c++)
            if (mq[c].size() > 0 && r[c]) void'(mq[c].pop_front());
        if (v && exp_rdy) begin
            if (sel == 2'b11) begin
                m_erro = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                mq[sel].push_back(d);
            end
        end
        for (int c = 0; c < 3; c++)
            if (mq[c].size() > 0) last_head[c] = mq[c][0];
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; select = 2'b00; data_in = 16'h0000;
        ready_in0 = 1'b0; ready_in1 = 1'b0; ready_in2 = 1'b0;
        m_reset();
        #1;
        check_outputs();
        @(posedge clock);
        #1;
        check_outputs();
        #2 reset = 1'b0;

        // Single word into channel 0, then drain it.
        cycle(1'b1, 2'b00, 16'hA5A5, 3'b000);
        cycle(1'b0, 2'b00, 16'h0000, 3'b001);

        // Channel 1 backpressure: third word refused, then in-order drain.
        cycle(1'b1, 2'b01, 16'h0001, 3'b000);
        cycle(1'b1, 2'b01, 16'h0002, 3'b000);
        cycle(1'b1, 2'b01, 16'h0003, 3'b010);
        cycle(1'b0, 2'b01, 16'h0000, 3'b010);
        cycle(1'b0, 2'b01, 16'h0000, 3'b010);

        // Full channel still refuses while being read in the same cycle.
        cycle(1'b1, 2'b00, 16'h0101, 3'b000);
        cycle(1'b1, 2'b00, 16'h0202, 3'b000);
        cycle(1'b1, 2'b00, 16'h0303, 3'b001);
        cycle(1'b0, 2'b00, 16'h0000, 3'b001);

        // Simultaneous write and read at count 1 on channel 2.
        cycle(1'b1, 2'b10, 16'h1111, 3'b000);
        cycle(1'b1, 2'b10, 16'h2222, 3'b100);
        cycle(1'b0, 2'b10, 16'h0000, 3'b100);

        // Invalid select: dropped, sticky error, saturating count after 256 drops.
        for (int i = 0; i < 256; i++) cycle(1'b1, 2'b11, 16'hFFFF, 3'b000);
        cycle(1'b1, 2'b11, 16'hFFFF, 3'b111);

        // Reset mid-cycle with channel 0 full: outputs clear without a clock edge.
        cycle(1'b1, 2'b00, 16'hBEEF, 3'b000);
        cycle(1'b1, 2'b00, 16'hCAFE, 3'b000);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        m_reset();
        #1;
        check_outputs();
        #1 reset = 1'b0;
        cycle(1'b1, 2'b00, 16'h1234, 3'b000);

        // Random traffic on all channels.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  16'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 16'h0000, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/demux_1_to_3_fifo.md
DEMUX_1_TO_3_FIFO -- requirements
Module: demux_1_to_3_fifo

Interface
REQ-001 Parameter: WIDTH, 16, data word width in bits.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  WIDTH  word to route.
REQ-005 select  input  2  destination: 2'b00 ch0, 2'b01 ch1, 2'b10 ch2, 2'b11 invalid.
REQ-006 valid_in  input  1  data_in/select valid this cycle.
REQ-007 ready_out  output  1  block accepts the word this cycle.
REQ-008 data_out0/1/2  output  WIDTH each  head word of channel FIFO 0/1/2.
REQ-009 valid_out0/1/2  output  1 each  channel FIFO non-empty.
REQ-010 ready_in0/1/2  input  1 each  consumer takes the head word this cycle.
REQ-011 erro  output  1  sticky flag: a word with select 2'b11 was accepted.
REQ-012 vazio  output  1  all three channel FIFOs empty.
REQ-013 err_count  output  8  dropped-word counter; present only with the macro in REQ-033.

Function
REQ-014 Transfer into block occurs on a rising edge with valid_in=1 and ready_out=1; transfer out of channel N occurs with valid_outN=1 and ready_inN=1.
REQ-015 Each channel holds a 2-entry FIFO of WIDTH-bit words with a 2-bit occupancy count (0..2).
REQ-016 ready_out is combinational: 1 if select=2'b11, else 1 if the selected FIFO count<2, else 0.
REQ-017 An accepted word with select 0/1/2 is written to that FIFO only; other FIFOs are unchanged.
REQ-018 Latency: an accepted word into an empty FIFO drives data_outN/valid_outN=1 from the next rising edge; no combinational input-to-output path.
REQ-019 FIFO order is preserved per channel; no ordering relation across channels.
REQ-020 Full FIFO (count=2): ready_out=0 for that select even if ready_inN=1 in the same cycle (no full pass-through).
REQ-021 Simultaneous write and read on a FIFO with count=1: count stays 1, new word becomes head next cycle.
REQ-022 Read with count=0 is impossible (valid_outN=0); ready_inN is ignored when empty.
REQ-023 Read pointers and write pointers wrap modulo 2.
REQ-024 Accepted word with select=2'b11 is discarded, no FIFO changes, erro set to 1 on that edge and held until reset.
REQ-025 Reads on all channels proceed independently and concurrently with any write.
REQ-026 vazio=1 exactly when all three counts are 0.
REQ-027 data_outN shows the head entry when valid_outN=1; value when valid_outN=0 is the last head or zero after reset.

Reset
REQ-028 reset=1 immediately, without a clock, clears all FIFO counts and pointers, storage, data_out0/1/2=0, valid_out0/1/2=0, erro=0, err_count=0, vazio=1.
REQ-029 Reset asserted mid-transfer discards all buffered words; no partial word survives.
REQ-030 While reset=1, ready_out may be 1 but no transfer is recorded.
REQ-031 First transfer is possible on the first rising edge after reset deasserts.

Configuration
REQ-032 Exactly one compile-time option exists.
REQ-033 With DEMUX_ERR_COUNT_EN defined: err_count port exists and increments by 1 per accepted select=2'b11 word, saturating at 255.
REQ-034 Without DEMUX_ERR_COUNT_EN: err_count port and its logic are absent; all other behaviour identical.

Verification
REQ-035 Reset, then write 16'hA5A5 sel 00 -> next edge valid_out0=1, data_out0=16'hA5A5, vazio=0; ch1/ch2 valid stay 0.
REQ-036 ready_in1=0, write 16'h0001, 16'h0002, 16'h0003 sel 01 -> third word sees ready_out=0; release ready_in1 -> reads 0001 then 0002 in order.
REQ-037 ch2 count=1 holding 16'h1111, same edge write 16'h2222 sel 10 and ready_in2=1 -> count stays 1, data_out2=16'h2222 next cycle.
REQ-038 Write 16'hFFFF sel 11 three times -> ready_out=1, no valid_out asserts, erro=1, err_count=3 (macro defined); 256 such writes -> err_count=255.
REQ-039 Fill ch0 with 2 words, assert reset mid-cycle -> outputs clear immediately, vazio=1, erro=0.
REQ-040 Random valid_in/select/ready_inN for 10000 cycles against scoreboard -> no loss, duplication or reordering per channel.
